// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin search helper for the stream multiplexer.
// The helper works on a fixed maximum channel count so every instance can share it.
package stream_mux_pkg;

    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] idx;
    } rr_pick_t;

    // Scan upward from the channel after 'last', wrapping at numCh-1 back to 0.
    function automatic rr_pick_t next_rr(
        input logic [MAX_CH-1:0]   valid,
        input logic [MAX_CH_W-1:0] last,
        input int                  numCh
    );
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            cand = int'(last) + k;
            if (cand >= numCh) begin
                cand = cand - numCh;
            end
            if ((k <= numCh) && !pick.found && valid[cand[MAX_CH_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[MAX_CH_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant search plus the last-grant pointer.
// The pointer only moves when the parent reports that a round-robin grant was taken.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic [SEL_W-1:0]  last_grant_q;
    logic [SEL_W-1:0]  last_grant_d;
    logic [MAX_CH-1:0] reqExt;
    rr_pick_t          pick;

    always_comb begin
        reqExt               = '0;
        reqExt[NUM_CH-1:0]   = req;
        pick                 = next_rr(reqExt, MAX_CH_W'(last_grant_q), NUM_CH);
        grant_idx            = SEL_W'(pick.idx);
        grant_vld            = pick.found;
        last_grant_d         = advance ? grant_idx : last_grant_q;
    end

    // Reset points at the highest channel so channel 0 wins the first search.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SEL_W'(NUM_CH - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select and round-robin modes.
// One output register stage; out_ch reports which channel produced out_data.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic             modeRr;
    logic             canLoad;
    logic             fixedVld;
    logic [SEL_W-1:0] rrIdx;
    logic             rrVld;
    logic [SEL_W-1:0] grantIdx;
    logic             grantVld;
    logic             take;
    logic             advance;
    logic [WIDTH-1:0] grantData;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (advance),
        .grant_idx (rrIdx),
        .grant_vld (rrVld)
    );

    // A select value with no matching channel simply never produces a grant.
    always_comb begin
        modeRr    = (mux_mode_e'(mode) == MODE_RR);
        canLoad   = ~out_valid_q | out_ready;
        fixedVld  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                fixedVld = in_valid[i];
            end
        end
        grantIdx  = modeRr ? rrIdx : sel;
        grantVld  = modeRr ? rrVld : fixedVld;
        take      = canLoad & grantVld & ~rst;
        advance   = take & modeRr;
        in_ready  = '0;
        grantData = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grantIdx == SEL_W'(i)) begin
                in_ready[i] = take;
                grantData   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = grantData;
            out_ch_d    = grantIdx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-free behavioural model.
module tb_stream_mux_rr;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    logic                    clk;
    logic                    rst;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    int assertCount = 0;
    int failCount   = 0;

    stream_mux_rr #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         mode;
        logic [1:0]   sel;
        logic [3:0]   valid;
        logic [127:0] data;
        logic         outReady;
        logic [3:0]   expReady;
        logic         expValid;
        logic [31:0]  expData;
        logic [1:0]   expCh;
    } vec_t;

    vec_t vecs[$];

    // Reference state: what the output slot holds and who was granted last in RR mode.
    logic        mValid;
    logic [31:0] mData;
    int          mCh;
    int          mLast;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic m, input logic [1:0] s,
                                 input logic [3:0] v, input logic [127:0] d, input logic o);
        rst       = r;
        mode      = m;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
    endtask

    task automatic addVec(input logic m, input logic [1:0] s, input logic [3:0] v,
                          input logic [127:0] d, input logic o, input logic [3:0] er,
                          input logic ev, input logic [31:0] ed, input logic [1:0] ec);
        vec_t t;
        t.mode = m; t.sel = s; t.valid = v; t.data = d; t.outReady = o;
        t.expReady = er; t.expValid = ev; t.expData = ed; t.expCh = ec;
        vecs.push_back(t);
    endtask

    function automatic int modelGrant();
        if (mode == 1'b0) begin
            return (int'(sel) < NUM_CH && in_valid[sel]) ? int'(sel) : -1;
        end
        for (int k = 1; k <= NUM_CH; k++) begin
            if (in_valid[(mLast + k) % NUM_CH]) return (mLast + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic logic [3:0] modelReady();
        int g;
        g = modelGrant();
        if (rst || (mValid && !out_ready) || g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic modelClock();
        int g;
        g = modelGrant();
        if (rst) begin
            mValid = 1'b0; mData = '0; mCh = 0; mLast = NUM_CH - 1;
        end else if ((!mValid || out_ready) && g >= 0) begin
            mValid = 1'b1;
            mData  = in_data[g*WIDTH +: WIDTH];
            mCh    = g;
            if (mode == 1'b1) mLast = g;
        end else if (out_ready) begin
            mValid = 1'b0;
        end
    endtask

    logic [127:0] dataRr;
    logic [127:0] dataFix;
    logic [127:0] dataBp;
    logic [127:0] dataRand;

    initial begin
        dataRr  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        dataFix = {32'h0, 32'h1111_2222, 32'h0, 32'h0};
        dataBp  = {32'hA3, 32'hA2, 32'hA1, 32'h1234_5678};

        addVec(0, 2, 4'b0100, dataFix, 1, 4'b0100, 1, 32'h1111_2222, 2);
        for (int i = 0; i < 6; i++) begin
            addVec(1, 0, 4'b1111, dataRr, 1, 4'(1 << (i % 4)), 1, 32'hA0 + 32'(i % 4), 2'(i % 4));
        end
        for (int i = 0; i < 4; i++) begin
            addVec(1, 0, 4'b1010, dataRr, 1, (i % 2 == 0) ? 4'b1000 : 4'b0010, 1,
                   (i % 2 == 0) ? 32'hA3 : 32'hA1, (i % 2 == 0) ? 2'd3 : 2'd1);
        end
        addVec(1, 0, 4'b0001, dataBp, 1, 4'b0001, 1, 32'h1234_5678, 0);
        for (int i = 0; i < 3; i++) begin
            addVec(1, 0, 4'b0010, dataBp, 0, 4'b0000, 1, 32'h1234_5678, 0);
        end
        addVec(1, 0, 4'b0010, dataBp, 1, 4'b0010, 1, 32'hA1, 1);
        addVec(0, 2, 4'b0001, dataRr, 1, 4'b0000, 0, 32'h0, 0);
        addVec(0, 2, 4'b0001, dataRr, 1, 4'b0000, 0, 32'h0, 0);
        addVec(1, 2, 4'b0001, dataRr, 1, 4'b0001, 1, 32'hA0, 0);

        applyStimulus(1, 0, 0, 4'b1111, dataRr, 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset out_data", 128'(out_data), 128'(0));
        checkOutput("reset out_ch", 128'(out_ch), 128'(0));
        checkOutput("reset in_ready", 128'(in_ready), 128'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].outReady);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].expReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d out_data", i), 128'(out_data), 128'(vecs[i].expData));
                checkOutput($sformatf("vec%0d out_ch", i), 128'(out_ch), 128'(vecs[i].expCh));
            end
        end

        // Stall one cycle, then reset while the slot is full and the consumer is ready.
        applyStimulus(0, 1, 0, 4'b0000, dataRr, 0);
        @(posedge clk);
        #1;
        checkOutput("stall hold valid", 128'(out_valid), 128'(1));
        checkOutput("stall hold data", 128'(out_data), 128'(32'hA0));
        applyStimulus(1, 1, 0, 4'b1111, dataRr, 1);
        #1;
        checkOutput("in_ready during rst", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("midrst out_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst out_data", 128'(out_data), 128'(0));
        checkOutput("midrst out_ch", 128'(out_ch), 128'(0));
        applyStimulus(0, 1, 0, 4'b1111, dataRr, 1);
        #1;
        checkOutput("post-rst in_ready", 128'(in_ready), 128'(4'b0001));
        @(posedge clk);
        #1;
        checkOutput("post-rst out_ch", 128'(out_ch), 128'(0));
        checkOutput("post-rst out_data", 128'(out_data), 128'(32'hA0));

        // Randomized traffic; start from a known reset so the model and DUT agree.
        mValid = 1'b0; mData = '0; mCh = 0; mLast = NUM_CH - 1;
        applyStimulus(1, 0, 0, 4'b0000, dataRr, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            dataRand = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom),
                          4'($urandom), dataRand, ($urandom_range(0, 3) != 0));
            #1;
            checkOutput($sformatf("rand%0d in_ready", c), 128'(in_ready), 128'(modelReady()));
            modelClock();
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d out_valid", c), 128'(out_valid), 128'(mValid));
            if (mValid) begin
                checkOutput($sformatf("rand%0d out_data", c), 128'(out_data), 128'(mData));
                checkOutput($sformatf("rand%0d out_ch", c), 128'(out_ch), 128'(mCh));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
